// File: rtl/seg_arb_pkg.sv
// ----------------------------------------------------------------------------
// seg_arb_pkg
//   Shared types and constants for the seven-segment display arbiter.
//   - seg_arb_state_t : arbiter FSM states (IDLE, GRANT)
//   - HEX_W / DIGITS / WORD_W : nibble width, digit count, per-requester word
//   - wrap_next()     : round-robin successor of an index modulo n
// ----------------------------------------------------------------------------
package seg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } seg_arb_state_t;

    localparam int HEX_W  = 4;
    localparam int DIGITS = 4;
    localparam int WORD_W = HEX_W * DIGITS;

    // Successor of idx in a ring of n entries (n-1 wraps back to 0).
    function automatic int unsigned wrap_next(int unsigned idx, int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. Searches req starting at
//   'start' and moving upward with wrap-around, returning the first hit.
//   Ports:
//     req    in  N_REQ  request vector
//     start  in  IDX_W  index that has highest priority this cycle
//     any    out 1      at least one request is set
//     index  out IDX_W  index of the winner (0 when none)
//     onehot out N_REQ  one-hot winner (0 when none)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             any,
    output logic [IDX_W-1:0] index,
    output logic [N_REQ-1:0] onehot
);

    int cand;

    // Scan offsets from farthest to nearest so the candidate closest to
    // 'start' is the last one written and therefore wins.
    always_comb begin
        any    = |req;
        index  = '0;
        onehot = '0;
        cand   = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = (int'(start) + off) % N_REQ;
            if (req[IDX_W'(cand)]) begin
                index = IDX_W'(cand);
            end
        end
        if (any) begin
            onehot = N_REQ'(1) << index;
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// ----------------------------------------------------------------------------
// seg_display_arbiter
//   Round-robin arbiter sharing a four-digit seven-segment display between
//   N_REQ requesters. Each grant owns the display for at least HOLD_CYCLES
//   clocks unless its owner drops its request first. Drives seven_seg_mux.
//
//   Configuration macro: SEG_ARB_BLANK_EN
//     defined   : an_en = 4'b0000 in IDLE/reset, 4'b1111 while granted
//     undefined : an_en = 4'b1111 always, last value stays visible in IDLE
//
//   Ports:
//     clk          in   1          system clock, rising edge
//     reset_n      in   1          asynchronous active-low reset
//     req          in   N_REQ      level requests
//     data         in   16*N_REQ   requester i word at [16*i +: 16]
//     dp_in        in   4*N_REQ    requester i decimal points at [4*i +: 4]
//     hex3..hex0   out  4 each     digit nibbles (hex3 = most significant)
//     dp_out       out  4          decimal points
//     an_en        out  4          digit enables
//     grant        out  N_REQ      one-hot owner, zero when idle
//     grant_valid  out  1          high while a requester owns the display
//     switch_tick  out  1          one-cycle pulse whenever grant changes
// ----------------------------------------------------------------------------
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [WORD_W*N_REQ-1:0]   data,
    input  logic [DIGITS*N_REQ-1:0]   dp_in,
    output logic [HEX_W-1:0]          hex3,
    output logic [HEX_W-1:0]          hex2,
    output logic [HEX_W-1:0]          hex1,
    output logic [HEX_W-1:0]          hex0,
    output logic [DIGITS-1:0]         dp_out,
    output logic [DIGITS-1:0]         an_en,
    output logic [N_REQ-1:0]          grant,
    output logic                      grant_valid,
    output logic                      switch_tick
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    seg_arb_state_t    state, state_next;
    logic [IDX_W-1:0]  owner, owner_next;
    logic [IDX_W-1:0]  rr_ptr, rr_next;
    logic [CNT_W-1:0]  hold_cnt, hold_next;
    logic              tick_next;

    logic [IDX_W-1:0]  pick_start;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  pick_onehot;

    logic [WORD_W-1:0] owner_word;
    logic [DIGITS-1:0] owner_dp;
    logic [WORD_W-1:0] hex_word;
    logic [DIGITS-1:0] dp_reg;

    // In IDLE the search resumes from the round-robin pointer; while granted
    // it starts just past the current owner so a release or expiry always
    // favours the next requester in ring order.
    assign pick_start = (state == IDLE) ? rr_ptr
                                        : IDX_W'(wrap_next(32'(owner), N_REQ));

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .start  (pick_start),
        .any    (pick_any),
        .index  (pick_idx),
        .onehot (pick_onehot)
    );

    // State register: FSM state, owner, hold counter, rr pointer and the
    // switch pulse. The display registers follow the owner's live data while
    // granted and freeze in IDLE so the last value stays on the digits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            switch_tick <= 1'b0;
            hex_word    <= '0;
            dp_reg      <= '0;
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            rr_ptr      <= rr_next;
            hold_cnt    <= hold_next;
            switch_tick <= tick_next;
            if (state == GRANT) begin
                hex_word <= owner_word;
                dp_reg   <= owner_dp;
            end
        end
    end

    // Next-state logic. A dropped owner request beats hold expiry; an expired
    // hold with nobody else waiting just reloads the counter on the same
    // owner. Picking from owner+1 can only return the owner itself when it is
    // the sole requester, which is why that case is treated as "stay".
    always_comb begin
        state_next = state;
        owner_next = owner;
        rr_next    = rr_ptr;
        hold_next  = hold_cnt;
        tick_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = GRANT;
                    owner_next = pick_idx;
                    rr_next    = IDX_W'(wrap_next(32'(pick_idx), N_REQ));
                    hold_next  = HOLD_RELOAD;
                    tick_next  = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    tick_next = 1'b1;
                    if (pick_any) begin
                        owner_next = pick_idx;
                        rr_next    = IDX_W'(wrap_next(32'(pick_idx), N_REQ));
                        hold_next  = HOLD_RELOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (hold_cnt == '0) begin
                    if (pick_any && (pick_idx != owner)) begin
                        owner_next = pick_idx;
                        rr_next    = IDX_W'(wrap_next(32'(pick_idx), N_REQ));
                        hold_next  = HOLD_RELOAD;
                        tick_next  = 1'b1;
                    end else begin
                        hold_next  = HOLD_RELOAD;
                    end
                end else begin
                    hold_next = hold_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Select the current owner's word and decimal points.
    always_comb begin
        owner_word = '0;
        owner_dp   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_word = data[i*WORD_W +: WORD_W];
                owner_dp   = dp_in[i*DIGITS +: DIGITS];
            end
        end
    end

    assign grant_valid = (state == GRANT);
    assign grant       = grant_valid ? (N_REQ'(1) << owner) : '0;

    assign hex3   = hex_word[4*HEX_W-1:3*HEX_W];
    assign hex2   = hex_word[3*HEX_W-1:2*HEX_W];
    assign hex1   = hex_word[2*HEX_W-1:HEX_W];
    assign hex0   = hex_word[HEX_W-1:0];
    assign dp_out = dp_reg;

`ifdef SEG_ARB_BLANK_EN
    assign an_en = grant_valid ? 4'b1111 : 4'b0000;
`else
    assign an_en = 4'b1111;
`endif

endmodule
